// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM block: position width,
// channel-index width helper and reset/slew defaults.
package servo_pkg;

  localparam int POS_W         = 8;
  localparam int RESET_POS_DEF = 128;
  localparam int SLEW_STEP_DEF = 4;

  // Channel index width: clog2 of the channel count, never narrower than one bit.
  function automatic int chw(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// Per-channel current-position register. cur only changes on a frame-start
// load, so the pulse width it drives is stable for a whole frame.
// Optional macro SERVO_SLEW_EN: limit each frame's move to SLEW_STEP units;
// without it the channel jumps straight to its target.
module servo_slew
  import servo_pkg::*;
#(
  parameter int RESET_POS = RESET_POS_DEF,
  parameter int SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [POS_W-1:0] target,
  output logic [POS_W-1:0] cur,
  output logic [POS_W-1:0] cur_next
);

  if (SLEW_STEP == 0) begin : g_bad_slew
    $error("servo_slew: SLEW_STEP must be non-zero");
  end

`ifdef SERVO_SLEW_EN
  // Step toward the target by at most SLEW_STEP, landing exactly on it when close.
  always_comb begin
    cur_next = cur;
    if (target > cur) begin
      if (32'(target - cur) > SLEW_STEP) begin
        cur_next = cur + POS_W'(SLEW_STEP);
      end else begin
        cur_next = target;
      end
    end else if (target < cur) begin
      if (32'(cur - target) > SLEW_STEP) begin
        cur_next = cur - POS_W'(SLEW_STEP);
      end else begin
        cur_next = target;
      end
    end else begin
      cur_next = target;
    end
  end
`else
  // Without slew limiting the channel takes its target directly.
  always_comb begin
    cur_next = target;
  end
`endif

  // Hold the current position, updating only on frame-start loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= POS_W'(RESET_POS);
    end else if (load) begin
      cur <= cur_next;
    end else begin
      cur <= cur;
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// target registers written through a valid/ready port, and registered pulses
// whose widths are latched at frame start.
// Optional macro SERVO_SLEW_EN: rate-limit position changes (see servo_slew).
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PERIOD_CYC = 200000,
  parameter int MIN_CYC    = 10000,
  parameter int STEP_CYC   = 40,
  parameter int RESET_POS  = RESET_POS_DEF,
  parameter int SLEW_STEP  = SLEW_STEP_DEF,
  localparam int CHW       = chw(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [POS_W-1:0] wr_pos,
  output logic             wr_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic             frame_start
);

  // Counter width; the longest pulse is below PERIOD_CYC so widths fit too.
  localparam int CW = $clog2(PERIOD_CYC);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_pwm_multi: NUM_CH must be 1..16");
  end
  if (MIN_CYC + 255 * STEP_CYC >= PERIOD_CYC) begin : g_bad_timing
    $error("servo_pwm_multi: longest pulse does not fit in the frame");
  end
  if (SLEW_STEP == 0) begin : g_bad_slew
    $error("servo_pwm_multi: SLEW_STEP must be non-zero");
  end

  logic [CW-1:0]    cnt_r;
  logic [POS_W-1:0] target_r   [NUM_CH];
  logic [POS_W-1:0] cur_s      [NUM_CH];
  logic [POS_W-1:0] cur_next_s [NUM_CH];
  logic [POS_W-1:0] sel_s      [NUM_CH];
  logic [CW-1:0]    width_s    [NUM_CH];
  logic [NUM_CH-1:0] pwm_next_s;
  logic             load_s;
  logic             accept_s;
  logic             ch_bad_s;

  // Ready tracks reset directly so the port is usable the moment reset drops.
  assign wr_ready = ~reset;
  assign accept_s = wr_valid & wr_ready;
  assign ch_bad_s = (32'(wr_ch) >= NUM_CH);
  assign load_s   = en & (cnt_r == CW'(0));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_slew #(
      .RESET_POS (RESET_POS),
      .SLEW_STEP (SLEW_STEP)
    ) u_slew (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .target   (target_r[g]),
      .cur      (cur_s[g]),
      .cur_next (cur_next_s[g])
    );
  end

  // Pulse widths: on the frame-start cycle use the position being loaded now.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i]      = load_s ? cur_next_s[i] : cur_s[i];
      width_s[i]    = CW'(MIN_CYC) + CW'(sel_s[i]) * CW'(STEP_CYC);
      pwm_next_s[i] = (cnt_r < width_s[i]);
    end
  end

  // Frame counter, target registers, write error flag and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= CW'(0);
      pwm_out     <= '0;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_r[i] <= POS_W'(RESET_POS);
      end
    end else begin
      wr_err <= accept_s & ch_bad_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_s && !ch_bad_s && (wr_ch == CHW'(i))) begin
          target_r[i] <= wr_pos;
        end else begin
          target_r[i] <= target_r[i];
        end
      end
      if (en) begin
        cnt_r       <= (cnt_r == CW'(PERIOD_CYC - 1)) ? CW'(0) : cnt_r + CW'(1);
        frame_start <= (cnt_r == CW'(0));
        pwm_out     <= pwm_next_s;
      end else begin
        cnt_r       <= CW'(0);
        frame_start <= 1'b0;
        pwm_out     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi (NUM_CH=2, PERIOD=300, MIN=10, STEP=1).
// A second instance with NUM_CH=3 exercises the out-of-range write error.
module tb_servo_pwm_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_ch;
  logic [7:0] wr_pos;
  logic       wr_err;
  logic [1:0] pwm_out;
  logic       frame_start;

  logic       wr_valid3;
  logic       wr_ready3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_pos3;
  logic       wr_err3;
  logic [2:0] pwm_out3;
  logic       frame_start3;

  int n_checks = 0;
  int n_errors = 0;
  int w3 [3];

  typedef struct {
    bit         do_wr;
    logic       ch;
    logic [7:0] pos;
    int         at;
    int         e0;
    int         e1;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(2), .PERIOD_CYC(300), .MIN_CYC(10), .STEP_CYC(1),
    .RESET_POS(128), .SLEW_STEP(4)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_pos(wr_pos), .wr_err(wr_err), .pwm_out(pwm_out),
    .frame_start(frame_start)
  );

  servo_pwm_multi #(
    .NUM_CH(3), .PERIOD_CYC(300), .MIN_CYC(10), .STEP_CYC(1),
    .RESET_POS(128), .SLEW_STEP(4)
  ) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .wr_ch(wr_ch3), .wr_pos(wr_pos3), .wr_err(wr_err3), .pwm_out(pwm_out3),
    .frame_start(frame_start3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for frame_start, then samples 300 cycles at negedge,
  // counting pulse widths and checking each pulse is one block from cycle 0.
  // An optional write is issued at negedge index 'at' for one cycle.
  task automatic run_frame(input bit do_wr, input logic ch, input logic [7:0] pos,
                           input int at, output int w0, output int w1,
                           output int wt, output bit shape_ok);
    bit lo0, lo1;
    bit lo3 [3];
    wt = 0; w0 = 0; w1 = 0; shape_ok = 1'b1; lo0 = 1'b0; lo1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w3[i] = 0; lo3[i] = 1'b0;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    while (frame_start !== 1'b1 && wt < 400) begin
      wt++;
      @(negedge clk);
    end
    if (wt >= 400) begin
      shape_ok = 1'b0;
      return;
    end
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (frame_start !== 1'b0) shape_ok = 1'b0;
      end
      if (pwm_out[0] === 1'b1) begin w0++; if (lo0) shape_ok = 1'b0; end else lo0 = 1'b1;
      if (pwm_out[1] === 1'b1) begin w1++; if (lo1) shape_ok = 1'b0; end else lo1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (pwm_out3[i] === 1'b1) begin w3[i]++; if (lo3[i]) shape_ok = 1'b0; end
        else lo3[i] = 1'b1;
      end
      if (do_wr && k == at) begin
        wr_valid = 1'b1; wr_ch = ch; wr_pos = pos;
      end else begin
        wr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, wt, hi_cnt;
    bit ok;

    reset = 1'b1; en = 1'b1; wr_valid = 1'b0; wr_ch = 1'b0; wr_pos = 8'd0;
    wr_valid3 = 1'b0; wr_ch3 = 2'd0; wr_pos3 = 8'd0;

`ifdef SERVO_SLEW_EN
    vecs.push_back('{1'b1, 1'b0, 8'd200, 100, 138, 138});
    for (int n = 1; n < 20; n++) begin
      vecs.push_back('{1'b0, 1'b0, 8'd0, 0, ((128 + 4 * n) < 200) ? (138 + 4 * n) : 210, 138});
    end
`else
    vecs.push_back('{1'b0, 1'b0, 8'd0,   0,   138, 138});
    vecs.push_back('{1'b1, 1'b1, 8'd0,   100, 138, 138});
    vecs.push_back('{1'b0, 1'b0, 8'd0,   0,   138, 10});
    vecs.push_back('{1'b1, 1'b0, 8'd50,  299, 138, 10});
    vecs.push_back('{1'b0, 1'b0, 8'd0,   0,   138, 10});
    vecs.push_back('{1'b1, 1'b1, 8'd255, 5,   60,  10});
    vecs.push_back('{1'b0, 1'b0, 8'd0,   0,   60,  265});
`endif

    // Reset state, with en already high to show reset wins.
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_wr_ready", int'(wr_ready), 0);
    check("reset_wr_err", int'(wr_err), 0);
    reset = 1'b0;

    // First frame after reset: both channels at the reset position.
    run_frame(1'b0, 1'b0, 8'd0, 0, w0, w1, wt, ok);
    check("first_fs_latency", wt, 0);
    check("first_w0", w0, 138);
    check("first_w1", w1, 138);
    check("first_shape", int'(ok), 1);
    check("wr_ready_after_reset", int'(wr_ready), 1);

    // Drop en at counter 100, hold low 20 cycles, then re-enable.
    for (int k = 0; k < 100; k++) @(negedge clk);
    check("pre_drop_pwm", int'(pwm_out), 3);
    en = 1'b0;
    @(negedge clk);
    check("drop_pwm", int'(pwm_out), 0);
    check("drop_frame_start", int'(frame_start), 0);
    hi_cnt = 0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (pwm_out !== 2'b00 || frame_start !== 1'b0) hi_cnt++;
    end
    check("disabled_quiet", hi_cnt, 0);
    en = 1'b1;
    run_frame(1'b0, 1'b0, 8'd0, 0, w0, w1, wt, ok);
    check("reenable_fs_latency", wt, 0);
    check("reenable_w0", w0, 138);
    check("reenable_w1", w1, 138);
    check("reenable_shape", int'(ok), 1);

    // Table of back-to-back frames with optional writes.
    for (int v = 0; v < vecs.size(); v++) begin
      run_frame(vecs[v].do_wr, vecs[v].ch, vecs[v].pos, vecs[v].at, w0, w1, wt, ok);
      check($sformatf("vec%0d_period", v), wt, 0);
      check($sformatf("vec%0d_w0", v), w0, vecs[v].e0);
      check($sformatf("vec%0d_w1", v), w1, vecs[v].e1);
      check($sformatf("vec%0d_shape", v), int'(ok), 1);
    end

    // Out-of-range channel on the three-channel instance.
    @(negedge clk);
    wr_valid3 = 1'b1; wr_ch3 = 2'd3; wr_pos3 = 8'd0;
    @(negedge clk);
    check("wr_err_pulse", int'(wr_err3), 1);
    wr_valid3 = 1'b1; wr_ch3 = 2'd2; wr_pos3 = 8'd128;
    @(negedge clk);
    check("wr_err_one_cycle", int'(wr_err3), 0);
    wr_valid3 = 1'b0;
    @(negedge clk);
    check("wr_err_valid_ch", int'(wr_err3), 0);
    check("wr_err_other_dut", int'(wr_err), 0);
    run_frame(1'b0, 1'b0, 8'd0, 0, w0, w1, wt, ok);
    check("err_frame_found", int'(wt < 400), 1);
    check("err_w3_0", w3[0], 138);
    check("err_w3_1", w3[1], 138);
    check("err_w3_2", w3[2], 138);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
